// File: rtl/cpu_oci_dct_pkg.sv
// cpu_oci_dct_pkg
// Shared widths and the capture-state type for the OCI trace packer.
//   DCT_BUF_W : width of the packed word handed to the OCI test-bench stage
//   DCT_CNT_W : width of the valid-symbol count that travels with each word
//   SYM_W     : width of one trace symbol
//   dct_state_e : capture FSM states (RUN, DRAIN, ENDED)
package cpu_oci_dct_pkg;

  localparam int DCT_BUF_W = 30;
  localparam int DCT_CNT_W = 4;
  localparam int SYM_W     = 2;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    ENDED = 2'd2
  } dct_state_e;

endpackage

// File: rtl/cpu_oci_dct_hold_reg.sv
// cpu_oci_dct_hold_reg
// One-entry output holding register with a valid/ready handoff.
// Ports:
//   clk, reset           : clock, synchronous active-high reset
//   load_i               : capture load_buf_i/load_cnt_i at this edge
//   load_buf_i/load_cnt_i: word and symbol count to capture
//   ready_i              : consumer takes the held word when valid_o && ready_i
//   free_o               : a load this cycle is allowed (empty or being handed off)
//   buf_o/cnt_o/valid_o  : registered word, count and valid flag
module cpu_oci_dct_hold_reg
  import cpu_oci_dct_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load_i,
  input  logic [DCT_BUF_W-1:0] load_buf_i,
  input  logic [DCT_CNT_W-1:0] load_cnt_i,
  input  logic                 ready_i,
  output logic                 free_o,
  output logic [DCT_BUF_W-1:0] buf_o,
  output logic [DCT_CNT_W-1:0] cnt_o,
  output logic                 valid_o
);

  logic [DCT_BUF_W-1:0] buf_q, buf_d;
  logic [DCT_CNT_W-1:0] cnt_q, cnt_d;
  logic                 valid_q, valid_d;

  assign free_o = !valid_q || ready_i;

  // Next-state: a load wins over a handoff so back-to-back words keep valid high.
  always_comb begin
    buf_d   = buf_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    if (load_i) begin
      buf_d   = load_buf_i;
      cnt_d   = load_cnt_i;
      valid_d = 1'b1;
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // Holding register state.
  always_ff @(posedge clk) begin
    if (reset) begin
      buf_q   <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      buf_q   <= buf_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
    end
  end

  assign buf_o   = buf_q;
  assign cnt_o   = cnt_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/cpu_oci_dct_packer.sv
// cpu_oci_dct_packer
// Packs 2-bit trace symbols into words of up to SYMS_PER_WORD symbols and
// hands them to the OCI test-bench stage through a one-entry holding register.
// Optional feature macro: DCT_DROP_COUNT_EN enables the saturating drop counter;
// without it drop_count is tied to zero and drops still happen silently.
// Ports:
//   clk, reset                : clock, synchronous active-high reset
//   sym_valid/sym_data        : incoming trace symbol (no backpressure)
//   flush                     : emit the partial word
//   test_end_req              : end capture (drain then stop)
//   dct_buffer/count/valid    : registered output word, handshaked by dct_ready
//   test_ending/test_has_ended: DRAIN / ENDED state flags
//   drop_count                : symbols lost while the accumulator was full and blocked
module cpu_oci_dct_packer
  import cpu_oci_dct_pkg::*;
#(
  parameter int SYMS_PER_WORD = 15,
  parameter int DROP_CNT_W    = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  sym_valid,
  input  logic [SYM_W-1:0]      sym_data,
  input  logic                  flush,
  input  logic                  test_end_req,
  output logic [DCT_BUF_W-1:0]  dct_buffer,
  output logic [DCT_CNT_W-1:0]  dct_count,
  output logic                  dct_valid,
  input  logic                  dct_ready,
  output logic                  test_ending,
  output logic                  test_has_ended,
  output logic [DROP_CNT_W-1:0] drop_count
);

  localparam logic [DCT_CNT_W-1:0] SPW = DCT_CNT_W'(SYMS_PER_WORD);

  logic [DCT_BUF_W-1:0] acc_q, acc_d, acc_w, load_buf_s;
  logic [DCT_CNT_W-1:0] cnt_q, cnt_d, cnt_w, load_cnt_s;
  logic                 pend_q, pend_d;
  dct_state_e           state_q;
  logic                 test_ending_q, test_has_ended_q;
  logic                 load_s, hold_free_s, accept_s, full_s, flush_req_s;

  // Symbols are only taken while running; the test_end_req cycle is still RUN.
  assign accept_s    = sym_valid && (state_q == RUN);
  assign full_s      = (cnt_q == SPW);
  // A pending flush keeps asking until the partial word gets out; DRAIN flushes implicitly.
  assign flush_req_s = (flush && (state_q == RUN)) || pend_q || (state_q == DRAIN);

  // Accumulator next-state and transfer decision.
  always_comb begin
    if (accept_s && !full_s) begin
      acc_w = {acc_q[DCT_BUF_W-SYM_W-1:0], sym_data};
      cnt_w = cnt_q + DCT_CNT_W'(1);
    end else begin
      acc_w = acc_q;
      cnt_w = cnt_q;
    end
    load_s     = 1'b0;
    load_buf_s = acc_w;
    load_cnt_s = cnt_w;
    acc_d      = acc_w;
    cnt_d      = cnt_w;
    pend_d     = 1'b0;
    if (full_s) begin
      // Full word waiting: it leaves at the first free edge, and a symbol
      // arriving on that edge starts the next word instead of being dropped.
      if (hold_free_s) begin
        load_s = 1'b1;
        if (accept_s) begin
          acc_d = {{(DCT_BUF_W-SYM_W){1'b0}}, sym_data};
          cnt_d = DCT_CNT_W'(1);
        end else begin
          acc_d = '0;
          cnt_d = '0;
        end
      end else begin
        acc_d = acc_q;
        cnt_d = cnt_q;
      end
    end else if (((cnt_w == SPW) || (flush_req_s && (cnt_w != '0))) && hold_free_s) begin
      load_s = 1'b1;
      acc_d  = '0;
      cnt_d  = '0;
    end else begin
      pend_d = flush_req_s && (cnt_w != '0);
    end
  end

  // Accumulator and pending-flush registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q  <= '0;
      cnt_q  <= '0;
      pend_q <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      cnt_q  <= cnt_d;
      pend_q <= pend_d;
    end
  end

  // Capture FSM with registered status flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= RUN;
      test_ending_q    <= 1'b0;
      test_has_ended_q <= 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          if (test_end_req) begin
            state_q       <= DRAIN;
            test_ending_q <= 1'b1;
          end
        end
        DRAIN: begin
          if ((cnt_q == '0) && !dct_valid) begin
            state_q          <= ENDED;
            test_ending_q    <= 1'b0;
            test_has_ended_q <= 1'b1;
          end
        end
        ENDED: begin
          state_q <= ENDED;
        end
        default: begin
          state_q          <= RUN;
          test_ending_q    <= 1'b0;
          test_has_ended_q <= 1'b0;
        end
      endcase
    end
  end

  assign test_ending    = test_ending_q;
  assign test_has_ended = test_has_ended_q;

  cpu_oci_dct_hold_reg u_hold (
    .clk        (clk),
    .reset      (reset),
    .load_i     (load_s),
    .load_buf_i (load_buf_s),
    .load_cnt_i (load_cnt_s),
    .ready_i    (dct_ready),
    .free_o     (hold_free_s),
    .buf_o      (dct_buffer),
    .cnt_o      (dct_count),
    .valid_o    (dct_valid)
  );

`ifdef DCT_DROP_COUNT_EN
  logic [DROP_CNT_W-1:0] drop_q;
  logic                  drop_s;

  assign drop_s = accept_s && full_s && !hold_free_s;

  // Saturating count of symbols lost to a full, blocked accumulator.
  always_ff @(posedge clk) begin
    if (reset) begin
      drop_q <= '0;
    end else if (drop_s && (drop_q != {DROP_CNT_W{1'b1}})) begin
      drop_q <= drop_q + DROP_CNT_W'(1);
    end else begin
      drop_q <= drop_q;
    end
  end

  assign drop_count = drop_q;
`else
  assign drop_count = '0;
`endif

endmodule

// File: tb/tb_cpu_oci_dct_packer.sv
module tb_cpu_oci_dct_packer;

  localparam int SPW = 15;
  localparam int DW  = 3;
`ifdef DCT_DROP_COUNT_EN
  localparam bit DROP_EN = 1'b1;
`else
  localparam bit DROP_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          sym_valid = 1'b0;
  logic [1:0]    sym_data = 2'd0;
  logic          flush = 1'b0;
  logic          test_end_req = 1'b0;
  logic [29:0]   dct_buffer;
  logic [3:0]    dct_count;
  logic          dct_valid;
  logic          dct_ready = 1'b1;
  logic          test_ending;
  logic          test_has_ended;
  logic [DW-1:0] drop_count;

  cpu_oci_dct_packer #(.SYMS_PER_WORD(SPW), .DROP_CNT_W(DW)) dut (
    .clk(clk), .reset(reset), .sym_valid(sym_valid), .sym_data(sym_data),
    .flush(flush), .test_end_req(test_end_req), .dct_buffer(dct_buffer),
    .dct_count(dct_count), .dct_valid(dct_valid), .dct_ready(dct_ready),
    .test_ending(test_ending), .test_has_ended(test_has_ended),
    .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: accumulator as a symbol queue, one holding slot, phase 0/1/2.
  int          m_acc[$];
  bit          m_hv;
  logic [29:0] m_hbuf;
  int          m_hcnt;
  int          m_ph;
  bit          m_pend;
  int          m_drops;

  function automatic logic [29:0] pack(input int q[$]);
    logic [29:0] b;
    b = 30'd0;
    foreach (q[i]) b = (b << 2) | 30'(q[i]);
    return b;
  endfunction

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_acc.delete();
    m_hv = 0; m_hbuf = 30'd0; m_hcnt = 0; m_ph = 0; m_pend = 0; m_drops = 0;
  endtask

  task automatic model_load();
    m_hbuf = pack(m_acc);
    m_hcnt = m_acc.size();
    m_hv   = 1;
    m_acc.delete();
  endtask

  task automatic model_step(input bit sv, input int sd, input bit fl, input bit te, input bit rd);
    bit free, acc_empty_old, hv_old, accept, want;
    int ph_old;
    ph_old = m_ph;
    acc_empty_old = (m_acc.size() == 0);
    hv_old = m_hv;
    free = !m_hv || rd;
    if (m_hv && rd) m_hv = 0;
    accept = sv && (ph_old == 0);
    if (m_acc.size() == SPW) begin
      m_pend = 0;
      if (free) begin
        model_load();
        if (accept) m_acc.push_back(sd);
      end else if (accept && m_drops < (1 << DW) - 1) begin
        m_drops++;
      end
    end else begin
      if (accept) m_acc.push_back(sd);
      want = (fl && ph_old == 0) || m_pend || (ph_old == 1);
      if ((m_acc.size() == SPW || (want && m_acc.size() > 0)) && free) begin
        model_load();
        m_pend = 0;
      end else begin
        m_pend = want && (m_acc.size() > 0);
      end
    end
    if (ph_old == 0 && te) m_ph = 1;
    else if (ph_old == 1 && acc_empty_old && !hv_old) m_ph = 2;
  endtask

  task automatic check_model();
    chk("m_valid", 64'(dct_valid), 64'(m_hv));
    chk("m_count", 64'(dct_count), 64'(m_hcnt));
    chk("m_buffer", 64'(dct_buffer), 64'(m_hbuf));
    chk("m_ending", 64'(test_ending), 64'(m_ph == 1));
    chk("m_ended", 64'(test_has_ended), 64'(m_ph == 2));
    chk("m_drops", 64'(drop_count), DROP_EN ? 64'(m_drops) : 64'd0);
  endtask

  // Drive inputs, clock once, advance the model, sample #1 after the edge.
  task automatic step(input bit r, input bit sv, input logic [1:0] sd,
                      input bit fl, input bit te, input bit rd);
    reset = r; sym_valid = sv; sym_data = sd; flush = fl; test_end_req = te; dct_ready = rd;
    @(posedge clk);
    if (r) model_reset();
    else model_step(sv, int'(sd), fl, te, rd);
    #1;
    check_model();
  endtask

  typedef struct {
    bit sv; logic [1:0] sd; bit fl; bit te; bit rd;
    bit chk_en; bit ev; logic [3:0] ec; logic [29:0] eb;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input bit sv, input logic [1:0] sd, input bit fl, input bit rd,
                              input bit ce, input bit ev, input logic [3:0] ec, input logic [29:0] eb);
    vec_t v;
    v.sv = sv; v.sd = sd; v.fl = fl; v.te = 1'b0; v.rd = rd;
    v.chk_en = ce; v.ev = ev; v.ec = ec; v.eb = eb;
    return v;
  endfunction

  initial begin
    bit seen4, emitted;
    logic [1:0] rs;

    // Reset state
    step(1, 0, 2'd0, 0, 0, 1);
    step(1, 0, 2'd0, 0, 0, 1);
    chk("rst_valid", 64'(dct_valid), 64'd0);
    chk("rst_count", 64'(dct_count), 64'd0);
    chk("rst_buffer", 64'(dct_buffer), 64'd0);
    chk("rst_flags", 64'({test_ending, test_has_ended}), 64'd0);
    chk("rst_drops", 64'(drop_count), 64'd0);

    // Directed table: full word of 2'b01, then 3,2,1 + flush, then empty flush.
    for (int i = 0; i < 14; i++) tbl.push_back(mk(1, 2'd1, 0, 1, 0, 0, 4'd0, 30'd0));
    tbl.push_back(mk(1, 2'd1, 0, 1, 1, 1, 4'd15, 30'h15555555));
    tbl.push_back(mk(0, 2'd0, 0, 1, 1, 0, 4'd15, 30'h15555555));
    tbl.push_back(mk(1, 2'd3, 0, 1, 0, 0, 4'd0, 30'd0));
    tbl.push_back(mk(1, 2'd2, 0, 1, 0, 0, 4'd0, 30'd0));
    tbl.push_back(mk(1, 2'd1, 0, 1, 0, 0, 4'd0, 30'd0));
    tbl.push_back(mk(0, 2'd0, 1, 1, 1, 1, 4'd3, 30'h39));
    tbl.push_back(mk(0, 2'd0, 1, 1, 1, 0, 4'd3, 30'h39));
    tbl.push_back(mk(1, 2'd2, 1, 1, 1, 1, 4'd1, 30'h2));
    for (int i = 0; i < tbl.size(); i++) begin
      step(0, tbl[i].sv, tbl[i].sd, tbl[i].fl, tbl[i].te, tbl[i].rd);
      if (tbl[i].chk_en) begin
        chk($sformatf("tbl%0d_valid", i), 64'(dct_valid), 64'(tbl[i].ev));
        if (tbl[i].ev) begin
          chk($sformatf("tbl%0d_count", i), 64'(dct_count), 64'(tbl[i].ec));
          chk($sformatf("tbl%0d_buffer", i), 64'(dct_buffer), 64'(tbl[i].eb));
        end
      end
    end

    // Blocked consumer: 35 symbols -> one held word, full accumulator, 5 drops.
    step(1, 0, 2'd0, 0, 0, 0);
    for (int i = 0; i < 35; i++) step(0, 1, 2'($urandom_range(3)), 0, 0, 0);
    chk("blk_valid", 64'(dct_valid), 64'd1);
    chk("blk_count", 64'(dct_count), 64'd15);
    chk("blk_drops", 64'(drop_count), DROP_EN ? 64'd5 : 64'd0);
    for (int i = 0; i < 5; i++) step(0, 1, 2'd3, 1, 0, 0);
    chk("blk_drop_sat", 64'(drop_count), DROP_EN ? 64'd7 : 64'd0);
    step(0, 0, 2'd0, 0, 0, 1);
    chk("blk_next_valid", 64'(dct_valid), 64'd1);
    chk("blk_next_count", 64'(dct_count), 64'd15);
    step(0, 0, 2'd0, 0, 0, 1);
    chk("blk_drained", 64'(dct_valid), 64'd0);

    // End of test: 4 symbols, test_end_req, drain, then ENDED ignores input.
    step(1, 0, 2'd0, 0, 0, 1);
    for (int i = 0; i < 4; i++) step(0, 1, 2'd2, 0, 0, 1);
    step(0, 0, 2'd0, 0, 1, 1);
    chk("end_ending", 64'(test_ending), 64'd1);
    seen4 = 0;
    for (int k = 0; k < 8 && !test_has_ended; k++) begin
      step(0, 0, 2'd0, 0, 0, 1);
      if (dct_valid && dct_count == 4'd4 && dct_buffer == 30'hAA) seen4 = 1;
    end
    chk("end_word4", 64'(seen4), 64'd1);
    chk("end_ended", 64'(test_has_ended), 64'd1);
    for (int i = 0; i < 5; i++) step(0, 1, 2'd1, 1, 1, 1);
    chk("end_ignore_valid", 64'(dct_valid), 64'd0);
    chk("end_ignore_flags", 64'({test_ending, test_has_ended}), 64'd1);

    // Reset mid-word with a held word: everything discarded.
    step(1, 0, 2'd0, 0, 0, 0);
    for (int i = 0; i < 22; i++) step(0, 1, 2'd1, 0, 0, 0);
    chk("mid_pre_valid", 64'(dct_valid), 64'd1);
    step(1, 0, 2'd0, 0, 0, 0);
    chk("mid_rst_outs", 64'({dct_buffer, dct_count, dct_valid, test_ending, test_has_ended}), 64'd0);
    emitted = 0;
    for (int i = 0; i < 20; i++) begin
      step(0, 0, 2'd0, 0, 0, 1);
      if (dct_valid) emitted = 1;
    end
    chk("mid_no_emit", 64'(emitted), 64'd0);

    // Randomized segments against the model.
    for (int seg = 0; seg < 6; seg++) begin
      step(1, 0, 2'd0, 0, 0, 1);
      for (int c = 0; c < 400; c++) begin
        rs = 2'($urandom_range(3));
        step(($urandom_range(399) == 0),
             ($urandom_range(9) < 7), rs,
             ($urandom_range(11) == 0),
             ($urandom_range(149) == 0),
             ($urandom_range(9) < 3 + seg));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cpu_oci_dct_packer.md
CPU_OCI_DCT_PACKER -- requirements
Module: cpu_oci_dct_packer

Interface
REQ-001 SHALL have parameter SYMS_PER_WORD, default 15, symbols per complete word (legal 1..15).
REQ-002 SHALL have parameter DROP_CNT_W, default 16, drop-counter width.
REQ-003 SHALL have port clk, input, 1, sole clock; all logic on rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port sym_valid, input, 1, trace symbol present this cycle (no backpressure from this block).
REQ-006 SHALL have port sym_data, input, 2, trace symbol.
REQ-007 SHALL have port flush, input, 1, single-cycle request to emit a partial word.
REQ-008 SHALL have port test_end_req, input, 1, single-cycle request to end capture.
REQ-009 SHALL have port dct_buffer, output, 30, packed word to the OCI test-bench stage.
REQ-010 SHALL have port dct_count, output, 4, number of valid symbols in dct_buffer.
REQ-011 SHALL have port dct_valid, output, 1, dct_buffer/dct_count hold a word.
REQ-012 SHALL have port dct_ready, input, 1, consumer accepts the word on the cycle when dct_valid && dct_ready.
REQ-013 SHALL have port test_ending, output, 1, drain in progress.
REQ-014 SHALL have port test_has_ended, output, 1, capture finished.
REQ-015 SHALL have port drop_count, output, DROP_CNT_W, saturating count of dropped symbols.

Function
REQ-016 Accumulator SHALL shift left by 2 on each accepted symbol and insert sym_data at bits [1:0]; valid symbols occupy bits [2*n-1:0]; unused upper bits SHALL be 0.
REQ-017 When an accepted symbol makes the accumulator count equal SYMS_PER_WORD, the word including that symbol SHALL load the holding register at the same edge if the holding register is empty or being handed off that cycle; the accumulator then clears to count 0.
REQ-018 If the holding register is blocked, the full accumulator SHALL hold; it SHALL transfer at the first edge when the holding register is free; symbols arriving while the accumulator is full and blocked SHALL be dropped.
REQ-019 dct_buffer, dct_count, dct_valid SHALL be registered, stable while dct_valid && !dct_ready, and dct_valid SHALL clear on handoff unless a new word loads the same edge.
REQ-020 flush with count>0 SHALL transfer the partial word under REQ-017/018 rules; flush with count 0 SHALL emit nothing; a symbol accepted in the flush cycle SHALL be included in the flushed word.
REQ-021 A flush raised while a transfer is blocked SHALL be held pending until the transfer completes.
REQ-022 The FSM SHALL have states RUN, DRAIN, and ENDED. RUN->DRAIN on test_end_req. DRAIN->ENDED when the accumulator count is 0 and the holding register is empty. ENDED persists until reset.
REQ-023 In DRAIN, a symbol on the test_end_req cycle SHALL be accepted; later symbols SHALL be ignored and not counted as drops; an implicit flush SHALL occur.
REQ-024 test_ending SHALL be 1 exactly in DRAIN; test_has_ended SHALL be 1 exactly in ENDED; in ENDED, symbols, flush, and test_end_req SHALL be ignored.
REQ-025 drop_count SHALL saturate at all-ones.

Reset
REQ-026 On reset SHALL set: dct_buffer=0, dct_count=0, dct_valid=0, accumulator empty, pending flush cleared, state RUN, test_ending=0, test_has_ended=0, drop_count=0.
REQ-027 Reset mid-word or mid-drain SHALL discard all data without emitting it.

Configuration
REQ-028 With DCT_DROP_COUNT_EN defined, REQ-025 counting SHALL be implemented.
REQ-029 Without DCT_DROP_COUNT_EN, drop_count SHALL be constant 0, drops SHALL still occur silently, and the port SHALL remain present.

Structure
REQ-030 Package cpu_oci_dct_pkg SHALL hold: DCT_BUF_W=30, DCT_CNT_W=4, SYM_W=2, and the FSM state enum type.
REQ-031 The holding register and its valid/ready logic SHALL be sub-module cpu_oci_dct_hold_reg; accumulator and FSM SHALL stay in the top module.

Verification
REQ-032 Scenario: 15 consecutive symbols 2'b01, dct_ready=1 -> one cycle after the 15th, dct_valid=1, dct_count=15, dct_buffer=30'h15555555.
REQ-033 Scenario: 3 symbols 3,2,1 then flush -> dct_count=3, dct_buffer=30'h39.
REQ-034 Scenario: dct_ready=0, send 35 symbols -> word 1 held, accumulator full at 15, 5 dropped, drop_count=5 (0 without macro).
REQ-035 Scenario: 4 symbols then test_end_req, dct_ready=1 -> test_ending=1, partial word emitted with count 4, then test_has_ended=1, later symbols ignored.
REQ-036 Scenario: reset asserted with 7 symbols accumulated and dct_valid=1 -> next cycle all outputs 0, state RUN, no word emitted after release.
